// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-master I/O bus arbiter: state encoding,
// timeout filler data and default bus sizes.
package io_bus_arbiter_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_ADR_BITS = 15;

  // Encoding doubles as the one-hot grant vector {m1,m0}
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// One Wishbone-style point-to-point link; the master modport drives the request,
// the slave modport returns read data and acknowledge.
interface io_bus_arbiter_if
  import io_bus_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADR_BITS = DEF_ADR_BITS
) ();

  logic [ADR_BITS-1:0] adr;
  logic [WIDTH-1:0]    dat_w;
  logic [WIDTH-1:0]    dat_r;
  logic                we;
  logic                stb;
  logic                ack;

  modport master (output adr, dat_w, we, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, output dat_r, ack);

endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between the MCU (m0) and the
// DMA/blitter (m1). Optional slave-ack timeout enabled by IO_ARB_TIMEOUT_EN.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADR_BITS = DEF_ADR_BITS,
  parameter int TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  io_bus_arbiter_if.slave         m0,
  io_bus_arbiter_if.slave         m1,
  io_bus_arbiter_if.master        s,
  output logic [1:0]              gnt_o,
  output logic                    err_o
);

  arb_state_e state_q;
  logic       last_q;
  logic       timeout_hit;

  assign gnt_o = state_q;

  // last_q remembers the most recently completed master; aborts leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0.stb && m1.stb) state_q <= last_q ? GNT0 : GNT1;
          else if (m0.stb)      state_q <= GNT0;
          else if (m1.stb)      state_q <= GNT1;
        end
        GNT0: begin
          if (!m0.stb) begin
            state_q <= IDLE;
          end else if (s.ack || timeout_hit) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1.stb) begin
            state_q <= IDLE;
          end else if (s.ack || timeout_hit) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             granted_stb;

  assign granted_stb = (state_q == GNT0) ? m0.stb : m1.stb;
  assign timeout_hit = (state_q != IDLE) && granted_stb && (cnt_q == CNT_W'(TIMEOUT));
  assign err_o       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (timeout_hit) begin
      cnt_q <= '0;
      err_q <= 1'b1;
    end else if (!s.ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // A forced termination answers the master itself and withdraws the slave strobe
  always_comb begin
    s.adr    = {ADR_BITS{1'b0}};
    s.dat_w  = {WIDTH{1'b0}};
    s.we     = 1'b0;
    s.stb    = 1'b0;
    m0.ack   = 1'b0;
    m0.dat_r = {WIDTH{1'b0}};
    m1.ack   = 1'b0;
    m1.dat_r = {WIDTH{1'b0}};
    case (state_q)
      GNT0: begin
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        s.we     = m0.we;
        s.stb    = m0.stb & ~timeout_hit;
        m0.ack   = (s.ack & m0.stb) | timeout_hit;
        m0.dat_r = timeout_hit ? WIDTH'(TIMEOUT_FILL) : s.dat_r;
      end
      GNT1: begin
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        s.we     = m1.we;
        s.stb    = m1.stb & ~timeout_hit;
        m1.ack   = (s.ack & m1.stb) | timeout_hit;
        m1.dat_r = timeout_hit ? WIDTH'(TIMEOUT_FILL) : s.dat_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter; the timeout scenario runs
// when IO_ARB_TIMEOUT_EN is defined, otherwise an indefinite-wait scenario runs.
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  localparam int WIDTH    = 32;
  localparam int ADR_BITS = 15;
`ifdef IO_ARB_TIMEOUT_EN
  localparam int TIMEOUT  = 4;
`else
  localparam int TIMEOUT  = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gnt;
  logic       err;
  int         checks   = 0;
  int         failures = 0;

  io_bus_arbiter_if #(.WIDTH(WIDTH), .ADR_BITS(ADR_BITS)) m0_bus ();
  io_bus_arbiter_if #(.WIDTH(WIDTH), .ADR_BITS(ADR_BITS)) m1_bus ();
  io_bus_arbiter_if #(.WIDTH(WIDTH), .ADR_BITS(ADR_BITS)) s_bus ();

  io_bus_arbiter #(.WIDTH(WIDTH), .ADR_BITS(ADR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt_o (gnt),
    .err_o (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic m0_stb, input logic m0_we, input logic [14:0] m0_adr,
                               input logic [31:0] m0_dat, input logic m1_stb, input logic m1_we,
                               input logic [14:0] m1_adr, input logic [31:0] m1_dat,
                               input logic s_ack, input logic [31:0] s_dat);
    m0_bus.stb   = m0_stb;
    m0_bus.we    = m0_we;
    m0_bus.adr   = m0_adr;
    m0_bus.dat_w = m0_dat;
    m1_bus.stb   = m1_stb;
    m1_bus.we    = m1_we;
    m1_bus.adr   = m1_adr;
    m1_bus.dat_w = m1_dat;
    s_bus.ack    = s_ack;
    s_bus.dat_r  = s_dat;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", gnt, 2'b00);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_s_stb", s_bus.stb, 1'b0);
    checkOutput("rst_m0_ack", m0_bus.ack, 1'b0);
    checkOutput("rst_m1_ack", m1_bus.ack, 1'b0);
    rst_n = 1'b1;

    $display("[TB] single m0 write with slave ack tied high");
    nextCycle();
    applyStimulus(1, 1, 15'h18, 32'h000000A5, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("t1_c0_gnt", gnt, 2'b00);
    checkOutput("t1_c0_s_stb", s_bus.stb, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_c1_gnt", gnt, 2'b01);
    checkOutput("t1_c1_m0_ack", m0_bus.ack, 1'b1);
    checkOutput("t1_c1_s_stb", s_bus.stb, 1'b1);
    checkOutput("t1_c1_s_dat", s_bus.dat_w, 32'h000000A5);
    checkOutput("t1_c1_s_adr", s_bus.adr, 15'h18);
    checkOutput("t1_c1_s_we", s_bus.we, 1'b1);
    checkOutput("t1_c1_m1_ack", m1_bus.ack, 1'b0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("t1_c2_gnt", gnt, 2'b00);
    checkOutput("t1_c2_s_stb", s_bus.stb, 1'b0);
    checkOutput("t1_c2_s_adr", s_bus.adr, 15'h0);

    $display("[TB] simultaneous requests alternate");
    doReset();
    nextCycle();
    applyStimulus(1, 0, 15'h1, 0, 1, 0, 15'h2, 0, 1, 32'h11);
    @(negedge clk);
    checkOutput("t2_c0_gnt", gnt, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_c1_gnt", gnt, 2'b01);
    checkOutput("t2_c1_m0_ack", m0_bus.ack, 1'b1);
    checkOutput("t2_c1_m0_dat", m0_bus.dat_r, 32'h11);
    checkOutput("t2_c1_m1_ack", m1_bus.ack, 1'b0);
    checkOutput("t2_c1_m1_dat", m1_bus.dat_r, 32'h0);
    checkOutput("t2_c1_s_adr", s_bus.adr, 15'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 15'h2, 0, 1, 32'h22);
    @(negedge clk);
    checkOutput("t2_c2_dead_gnt", gnt, 2'b00);
    checkOutput("t2_c2_m1_ack", m1_bus.ack, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_c3_gnt", gnt, 2'b10);
    checkOutput("t2_c3_m1_ack", m1_bus.ack, 1'b1);
    checkOutput("t2_c3_m1_dat", m1_bus.dat_r, 32'h22);
    checkOutput("t2_c3_m0_dat", m0_bus.dat_r, 32'h0);
    checkOutput("t2_c3_s_adr", s_bus.adr, 15'h2);
    nextCycle();
    applyStimulus(1, 0, 15'h1, 0, 1, 0, 15'h2, 0, 1, 32'h33);
    @(negedge clk);
    checkOutput("t2_c4_gnt", gnt, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_c5_alt_gnt", gnt, 2'b01);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t2_c6_gnt", gnt, 2'b00);

    $display("[TB] m1 read with delayed slave ack");
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 15'h10, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_c0_gnt", gnt, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      if (i == 4) applyStimulus(0, 0, 0, 0, 1, 0, 15'h10, 0, 1, 32'h12345678);
      @(negedge clk);
      checkOutput($sformatf("t3_c%0d_gnt", i), gnt, 2'b10);
      checkOutput($sformatf("t3_c%0d_s_stb", i), s_bus.stb, 1'b1);
      checkOutput($sformatf("t3_c%0d_s_adr", i), s_bus.adr, 15'h10);
      checkOutput($sformatf("t3_c%0d_m0_ack", i), m0_bus.ack, 1'b0);
      checkOutput($sformatf("t3_c%0d_m1_ack", i), m1_bus.ack, (i == 4));
      if (i == 4) checkOutput("t3_c4_m1_dat", m1_bus.dat_r, 32'h12345678);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t3_c5_gnt", gnt, 2'b00);
    checkOutput("t3_c5_s_stb", s_bus.stb, 1'b0);

    $display("[TB] m0 abort with m1 pending");
    nextCycle();
    applyStimulus(1, 0, 15'h3, 0, 1, 0, 15'h4, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4a_c0_gnt", gnt, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("t4a_c1_gnt", gnt, 2'b01);
    checkOutput("t4a_c1_s_stb", s_bus.stb, 1'b1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 15'h4, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4a_c2_s_stb", s_bus.stb, 1'b0);
    checkOutput("t4a_c2_m0_ack", m0_bus.ack, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4a_c3_gnt", gnt, 2'b00);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 15'h4, 0, 1, 32'h44);
    @(negedge clk);
    checkOutput("t4a_c4_gnt", gnt, 2'b10);
    checkOutput("t4a_c4_m1_ack", m1_bus.ack, 1'b1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4a_c5_gnt", gnt, 2'b00);

    $display("[TB] abort leaves round-robin pointer unchanged");
    nextCycle();
    applyStimulus(1, 0, 15'h5, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4b_c1_gnt", gnt, 2'b01);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 15'h5, 0, 1, 0, 15'h6, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4b_c3_gnt", gnt, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("t4b_c4_last_kept", gnt, 2'b01);
    nextCycle();
    applyStimulus(1, 0, 15'h5, 0, 0, 0, 0, 0, 1, 32'h55);
    @(negedge clk);
    checkOutput("t4b_c5_m0_ack", m0_bus.ack, 1'b1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4b_c6_gnt", gnt, 2'b00);

    $display("[TB] asynchronous reset during m1 grant");
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 15'h7, 32'h77, 0, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_pre_gnt", gnt, 2'b10);
    #2 s_bus.ack = 1'b1;
    #1 checkOutput("t5_pre_m1_ack", m1_bus.ack, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_gnt", gnt, 2'b00);
    checkOutput("t5_rst_s_stb", s_bus.stb, 1'b0);
    checkOutput("t5_rst_m1_ack", m1_bus.ack, 1'b0);
    checkOutput("t5_rst_m0_ack", m0_bus.ack, 1'b0);
    nextCycle();
    applyStimulus(1, 0, 15'h8, 0, 1, 0, 15'h9, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_rel_gnt", gnt, 2'b00);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_dual_after_rst", gnt, 2'b01);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_end_gnt", gnt, 2'b00);

`ifdef IO_ARB_TIMEOUT_EN
    $display("[TB] slave never acks, timeout terminates m0");
    nextCycle();
    applyStimulus(1, 1, 15'h5, 32'hAA, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("t6_c%0d_gnt", i), gnt, 2'b01);
      checkOutput($sformatf("t6_c%0d_m0_ack", i), m0_bus.ack, (i == 5));
      checkOutput($sformatf("t6_c%0d_s_stb", i), s_bus.stb, (i != 5));
      checkOutput($sformatf("t6_c%0d_err", i), err, 1'b0);
      if (i == 5) checkOutput("t6_fill_dat", m0_bus.dat_r, 32'hDEADBEEF);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_err_set", err, 1'b1);
    checkOutput("t6_idle_gnt", gnt, 2'b00);
    checkOutput("t6_idle_m0_ack", m0_bus.ack, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6_err_sticky", err, 1'b1);
`else
    $display("[TB] slave never acks, grant held indefinitely");
    nextCycle();
    applyStimulus(1, 1, 15'h5, 32'hAA, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("t6_c%0d_gnt", i), gnt, 2'b01);
      checkOutput($sformatf("t6_c%0d_m0_ack", i), m0_bus.ack, 1'b0);
      checkOutput($sformatf("t6_c%0d_s_stb", i), s_bus.stb, 1'b1);
      checkOutput($sformatf("t6_c%0d_err", i), err, 1'b0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6_abort_gnt", gnt, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
